// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: baud constants and the
// arbiter state encoding.
package uart_pkg;

  localparam int CLK_HZ       = 12000000;
  localparam int BAUD         = 115200;
  localparam int CLKS_IN_BAUD = CLK_HZ / BAUD;

  typedef enum logic [2:0] {
    ARB_IDLE      = 3'd0,
    ARB_REQ       = 3'd1,
    ARB_WAIT_BUSY = 3'd2,
    ARB_WAIT_DONE = 3'd3,
    ARB_HOLD      = 3'd4
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker. The search starts at last_grant+1 and
// wraps, so the requester served most recently has the lowest priority.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  logic [IDX_W-1:0] hi_idx_s;
  logic [IDX_W-1:0] lo_idx_s;
  logic             hi_ok_s;
  logic             lo_ok_s;

  // Find the lowest requesting index above last_grant and the lowest at or below it
  always_comb begin
    hi_idx_s = '0;
    lo_idx_s = '0;
    hi_ok_s  = 1'b0;
    lo_ok_s  = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req[j] && (j > int'(last_grant))) begin
        hi_idx_s = IDX_W'(j);
        hi_ok_s  = 1'b1;
      end else if (req[j]) begin
        lo_idx_s = IDX_W'(j);
        lo_ok_s  = 1'b1;
      end else begin
        hi_ok_s = hi_ok_s;
      end
    end
  end

  // Indices above last_grant come first in ring order; otherwise wrap around
  always_comb begin
    gnt       = '0;
    gnt_valid = hi_ok_s | lo_ok_s;
    gnt_idx   = hi_ok_s ? hi_idx_s : lo_idx_s;
    if (gnt_valid) begin
      gnt[gnt_idx] = 1'b1;
    end else begin
      gnt = '0;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares the UART transmit path between NUM_REQ requesters with round-robin
// grant and packet lock. Bytes lost to an RX collision are re-requested, and a
// request the UART never acknowledges is retried after BUSY_TIMEOUT cycles.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  input  logic [8*NUM_REQ-1:0] req_byte,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           uart_tx_byte,
  output logic                 uart_send_request,
  input  logic                 uart_busy,
  input  logic                 uart_byte_available
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  arb_state_t         state_r;
  arb_state_t         state_next_s;
  logic [IDX_W-1:0]   last_grant_r;
  logic [IDX_W-1:0]   owner_r;
  logic [IDX_W-1:0]   pick_idx_s;
  logic [IDX_W-1:0]   load_idx_s;
  logic [NUM_REQ-1:0] pick_gnt_s;
  logic               pick_valid_s;
  logic [NUM_REQ-1:0] grant_r;
  logic [NUM_REQ-1:0] ready_s;
  logic               last_flag_r;
  logic [7:0]         tx_byte_r;
  logic               send_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               load_byte_s;
  logic               take_grant_s;
  logic               release_s;
  logic               clr_cnt_s;
  logic               inc_cnt_s;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant_r),
    .gnt        (pick_gnt_s),
    .gnt_idx    (pick_idx_s),
    .gnt_valid  (pick_valid_s)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ARB_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode plus the datapath strobes and the Mealy ready pulse
  always_comb begin
    state_next_s = state_r;
    ready_s      = '0;
    load_byte_s  = 1'b0;
    take_grant_s = 1'b0;
    release_s    = 1'b0;
    clr_cnt_s    = 1'b0;
    inc_cnt_s    = 1'b0;
    load_idx_s   = owner_r;
    case (state_r)
      ARB_IDLE: begin
        load_idx_s = pick_idx_s;
        // A busy UART may still be framing (RX, or a TX from before reset)
        if (!uart_busy && pick_valid_s) begin
          load_byte_s  = 1'b1;
          take_grant_s = 1'b1;
          state_next_s = ARB_REQ;
        end else begin
          state_next_s = ARB_IDLE;
        end
      end
      ARB_REQ: begin
        clr_cnt_s    = 1'b1;
        state_next_s = ARB_WAIT_BUSY;
      end
      ARB_WAIT_BUSY: begin
        if (uart_busy) begin
          state_next_s = ARB_WAIT_DONE;
        end else if (cnt_r == CNT_W'(BUSY_TIMEOUT - 1)) begin
          state_next_s = ARB_REQ;
        end else begin
          inc_cnt_s    = 1'b1;
          state_next_s = ARB_WAIT_BUSY;
        end
      end
      ARB_WAIT_DONE: begin
        if (uart_busy) begin
          state_next_s = ARB_WAIT_DONE;
        end else if (uart_byte_available) begin
          // The UART served an RX frame instead; the byte was never sent
          state_next_s = ARB_REQ;
        end else begin
          ready_s = grant_r;
          if (last_flag_r) begin
            release_s    = 1'b1;
            state_next_s = ARB_IDLE;
          end else begin
            state_next_s = ARB_HOLD;
          end
        end
      end
      ARB_HOLD: begin
        if (req_valid[owner_r]) begin
          load_byte_s  = 1'b1;
          state_next_s = ARB_REQ;
        end else begin
          state_next_s = ARB_HOLD;
        end
      end
      default: begin
        state_next_s = ARB_IDLE;
      end
    endcase
  end

  // Grant ownership and the round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_r      <= '0;
      owner_r      <= '0;
      last_grant_r <= IDX_W'(NUM_REQ - 1);
    end else if (take_grant_s) begin
      grant_r <= pick_gnt_s;
      owner_r <= pick_idx_s;
    end else if (release_s) begin
      grant_r      <= '0;
      last_grant_r <= owner_r;
    end
  end

  // Byte latch: the UART samples tx_byte live, so it moves only between frames
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_byte_r   <= 8'h00;
      last_flag_r <= 1'b0;
    end else if (load_byte_s) begin
      tx_byte_r   <= req_byte[{load_idx_s, 3'b000} +: 8];
      last_flag_r <= req_last[load_idx_s];
    end
  end

  // Busy-acknowledge timeout counter and the registered one-cycle request
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r  <= '0;
      send_r <= 1'b0;
    end else begin
      send_r <= (state_next_s == ARB_REQ);
      if (clr_cnt_s) begin
        cnt_r <= '0;
      end else if (inc_cnt_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign grant             = grant_r;
  assign req_ready         = ready_s;
  assign uart_tx_byte      = tx_byte_r;
  assign uart_send_request = send_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a shortened-frame UART model and
// table-driven requesters that hold each byte until it is accepted.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ      = 4;
  localparam int BUSY_TIMEOUT = 4;
  localparam int FRAME        = 12;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_last;
  logic [8*NUM_REQ-1:0] req_byte;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   grant;
  logic [7:0]           uart_tx_byte;
  logic                 uart_send_request;
  logic                 uart_busy = 1'b0;
  logic                 uart_byte_available = 1'b0;

  // bench control, written only by the main initial block
  logic [NUM_REQ-1:0] req_en;
  logic               tb_clear;
  logic               stall;
  logic               chk_stable;
  int                 collide_req;
  logic [7:0]         pkt_byte [NUM_REQ][8];
  logic               pkt_last [NUM_REQ][8];
  int                 pkt_len  [NUM_REQ];

  // observation state, written only by the always blocks
  int         busy_cnt = 0;
  logic       rx_mode = 1'b0;
  logic [7:0] frame_byte = 8'h00;
  int         req_seen = 0;
  logic [7:0] tx_log [16];
  int         log_n = 0;
  int         unstable_n = 0;
  int         ptr [NUM_REQ];
  int         rdy_cnt [NUM_REQ];
  int         rdy_log [16];
  int         rdy_n = 0;
  int         pulse_n = 0;

  int n_tests = 0;
  int n_fail  = 0;
  int p0;

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_valid           (req_valid),
    .req_last            (req_last),
    .req_byte            (req_byte),
    .req_ready           (req_ready),
    .grant               (grant),
    .uart_tx_byte        (uart_tx_byte),
    .uart_send_request   (uart_send_request),
    .uart_busy           (uart_busy),
    .uart_byte_available (uart_byte_available)
  );

  always #5 clk = ~clk;

  // Requesters present the byte at their table pointer while enabled
  always_comb begin
    req_valid = '0;
    req_last  = '0;
    req_byte  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]       = req_en[i] && (ptr[i] < pkt_len[i]);
      req_last[i]        = pkt_last[i][ptr[i][2:0]];
      req_byte[8*i +: 8] = pkt_byte[i][ptr[i][2:0]];
    end
  end

  // UART model: a request starts a FRAME-cycle TX (or an RX on collision)
  always @(posedge clk) begin
    uart_byte_available <= 1'b0;
    if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (!rx_mode && chk_stable && (uart_tx_byte !== frame_byte)) begin
        unstable_n <= unstable_n + 1;
      end
      if (busy_cnt == 1) begin
        uart_busy           <= 1'b0;
        uart_byte_available <= rx_mode;
        if (!rx_mode) begin
          tx_log[log_n[3:0]] <= frame_byte;
          log_n              <= log_n + 1;
        end
      end
    end else if (uart_send_request && !stall) begin
      busy_cnt   <= FRAME;
      uart_busy  <= 1'b1;
      rx_mode    <= (req_seen == collide_req);
      req_seen   <= req_seen + 1;
      frame_byte <= uart_tx_byte;
    end
    if (tb_clear) begin
      log_n      <= 0;
      unstable_n <= 0;
    end
  end

  // Handshake bookkeeping: advance requester pointers and log completions
  always @(posedge clk) begin
    if (uart_send_request) begin
      pulse_n <= pulse_n + 1;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        ptr[i]             <= ptr[i] + 1;
        rdy_cnt[i]         <= rdy_cnt[i] + 1;
        rdy_log[rdy_n[3:0]] <= i;
        rdy_n              <= rdy_n + 1;
      end
    end
    if (tb_clear) begin
      rdy_n <= 0;
      for (int i = 0; i < NUM_REQ; i++) begin
        ptr[i]     <= 0;
        rdy_cnt[i] <= 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_pkt(input int r, input int k, input logic [7:0] b, input logic l);
    pkt_byte[r][k] = b;
    pkt_last[r][k] = l;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    tb_clear    = 1'b1;
    req_en      = '0;
    stall       = 1'b0;
    collide_req = -1;
    for (int r = 0; r < NUM_REQ; r++) pkt_len[r] = 0;
    @(negedge clk);
    rst      = 1'b0;
    tb_clear = 1'b0;
  endtask

  initial begin
    chk_stable = 1'b1;
    for (int r = 0; r < NUM_REQ; r++) begin
      for (int k = 0; k < 8; k++) set_pkt(r, k, 8'h00, 1'b1);
    end
    @(negedge clk);
    do_reset();

    // reset values
    check("rst_grant", grant, 32'h0);
    check("rst_ready", req_ready, 32'h0);
    check("rst_send", uart_send_request, 32'h0);
    check("rst_txbyte", uart_tx_byte, 32'h0);

    // single byte from requester 2
    set_pkt(2, 0, 8'hA5, 1'b1);
    pkt_len[2] = 1;
    req_en     = 4'b0100;
    step(1);
    check("single_grant", grant, 32'h4);
    check("single_send_hi", uart_send_request, 32'h1);
    check("single_txbyte", uart_tx_byte, 32'hA5);
    step(1);
    check("single_send_lo", uart_send_request, 32'h0);
    check("single_busy", uart_busy, 32'h1);
    step(12);
    check("single_ready", req_ready, 32'h4);
    step(1);
    check("single_grant_clr", grant, 32'h0);
    check("single_ready_lo", req_ready, 32'h0);
    step(20);
    check("single_rdy_cnt", rdy_cnt[2], 32'd1);
    check("single_log_n", log_n, 32'd1);
    check("single_log0", tx_log[0], 32'hA5);
    check("single_pulses", pulse_n, 32'd1);

    // fairness: all four valid, requester 0 has a second packet
    do_reset();
    set_pkt(0, 0, 8'h10, 1'b1);
    set_pkt(0, 1, 8'h10, 1'b1);
    set_pkt(1, 0, 8'h11, 1'b1);
    set_pkt(2, 0, 8'h12, 1'b1);
    set_pkt(3, 0, 8'h13, 1'b1);
    pkt_len[0] = 2;
    pkt_len[1] = 1;
    pkt_len[2] = 1;
    pkt_len[3] = 1;
    req_en     = 4'b1111;
    step(120);
    check("fair_log_n", log_n, 32'd5);
    check("fair_tx0", tx_log[0], 32'h10);
    check("fair_tx1", tx_log[1], 32'h11);
    check("fair_tx2", tx_log[2], 32'h12);
    check("fair_tx3", tx_log[3], 32'h13);
    check("fair_tx4", tx_log[4], 32'h10);
    check("fair_rdy1", rdy_log[1], 32'd1);
    check("fair_rdy3", rdy_log[3], 32'd3);
    check("fair_rdy4", rdy_log[4], 32'd0);

    // packet lock: requester 1 sends three bytes while requester 0 waits
    do_reset();
    set_pkt(1, 0, 8'h21, 1'b0);
    set_pkt(1, 1, 8'h22, 1'b0);
    set_pkt(1, 2, 8'h23, 1'b1);
    set_pkt(0, 0, 8'h05, 1'b1);
    pkt_len[1] = 3;
    pkt_len[0] = 1;
    req_en     = 4'b0010;
    step(3);
    req_en = 4'b0011;
    step(17);
    check("lock_grant_mid", grant, 32'h2);
    step(80);
    check("lock_log_n", log_n, 32'd4);
    check("lock_tx0", tx_log[0], 32'h21);
    check("lock_tx1", tx_log[1], 32'h22);
    check("lock_tx2", tx_log[2], 32'h23);
    check("lock_tx3", tx_log[3], 32'h05);
    check("lock_rdy2", rdy_log[2], 32'd1);
    check("lock_rdy3", rdy_log[3], 32'd0);

    // RX collision on the first request
    do_reset();
    set_pkt(3, 0, 8'h3C, 1'b1);
    pkt_len[3]  = 1;
    collide_req = req_seen;
    p0          = pulse_n;
    req_en      = 4'b1000;
    step(14);
    check("coll_avail", uart_byte_available, 32'h1);
    check("coll_ready_lo", req_ready, 32'h0);
    step(1);
    check("coll_resend", uart_send_request, 32'h1);
    check("coll_resend_byte", uart_tx_byte, 32'h3C);
    step(40);
    check("coll_pulses", pulse_n - p0, 32'd2);
    check("coll_rdy_cnt", rdy_cnt[3], 32'd1);
    check("coll_log_n", log_n, 32'd1);
    check("coll_tx0", tx_log[0], 32'h3C);
    collide_req = -1;

    // reset in the middle of a frame
    do_reset();
    set_pkt(2, 0, 8'h77, 1'b1);
    set_pkt(0, 0, 8'h0A, 1'b1);
    pkt_len[2] = 1;
    pkt_len[0] = 1;
    chk_stable = 1'b0;
    req_en     = 4'b0100;
    step(5);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("mid_rst_grant", grant, 32'h0);
    check("mid_rst_send", uart_send_request, 32'h0);
    check("mid_rst_txbyte", uart_tx_byte, 32'h0);
    check("mid_rst_ready", req_ready, 32'h0);
    req_en = 4'b0101;
    p0     = pulse_n;
    step(7);
    check("mid_busy_held", uart_busy, 32'h1);
    step(1);
    check("mid_no_req", pulse_n - p0, 32'd0);
    check("mid_send_lo", uart_send_request, 32'h0);
    step(1);
    check("mid_send_hi", uart_send_request, 32'h1);
    check("mid_grant0", grant, 32'h1);
    check("mid_txbyte", uart_tx_byte, 32'h0A);
    step(60);
    check("mid_log_n", log_n, 32'd3);
    check("mid_tx1", tx_log[1], 32'h0A);
    check("mid_tx2", tx_log[2], 32'h77);
    check("mid_rdy0", rdy_log[0], 32'd0);
    check("mid_rdy1", rdy_log[1], 32'd2);
    chk_stable = 1'b1;

    // busy timeout with a stalled UART
    do_reset();
    set_pkt(1, 0, 8'h99, 1'b1);
    pkt_len[1] = 1;
    stall      = 1'b1;
    req_en     = 4'b0010;
    for (int c = 1; c <= 12; c++) begin
      step(1);
      check($sformatf("tmo_send_c%0d", c), uart_send_request,
            {31'd0, (c == 1) || (c == 6) || (c == 11)});
      check($sformatf("tmo_byte_c%0d", c), uart_tx_byte, 32'h99);
    end
    stall = 1'b0;
    step(40);
    check("tmo_rdy_cnt", rdy_cnt[1], 32'd1);
    check("tmo_log_n", log_n, 32'd1);
    check("tmo_tx0", tx_log[0], 32'h99);
    check("tx_byte_stable", unstable_n, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single transmit path of the `uart` block between `NUM_REQ` on-chip requesters. Requesters present bytes on a valid/ready handshake, and grant is round-robin with packet lock: a requester keeps the UART until it flags its last byte. The block sits directly in front of `uart`. It drives `tx_byte` and `send_request`, and it watches `busy` and `byte_available` to sequence each byte. It also retries any byte lost to an RX collision.

## Interface
- `NUM_REQ`, 4 — number of requesters (2..8).
- `BUSY_TIMEOUT`, 4 — cycles to wait for `uart_busy` to rise after a request before re-requesting.
- `clk` in 1 — the single clock for the block.
- `rst` in 1 — reset; synchronous, active-high.
- `req_valid` in NUM_REQ — per-requester byte valid.
- `req_last` in NUM_REQ — marks the offered byte as the last byte of its packet.
- `req_byte` in 8*NUM_REQ — byte for requester i on bits [8i+7:8i].
- `req_ready` out NUM_REQ — one-cycle acceptance pulse; the byte is complete when `req_valid & req_ready`.
- `grant` out NUM_REQ — one-hot owner of the UART; all zeros when no requester owns it.
- `uart_tx_byte` out 8 — goes to `uart.tx_byte`.
- `uart_send_request` out 1 — goes to `uart.send_request`.
- `uart_busy` in 1 — comes from `uart.busy`.
- `uart_byte_available` in 1 — comes from `uart.byte_available`.

## Operation
- **States:** IDLE, REQ, WAIT_BUSY, WAIT_DONE, HOLD.
- **IDLE:**
  - Acts only when `uart_busy`=0 and at least one `req_valid` is high.
  - Picks a requester round-robin, starting from `last_grant+1`.
  - Registers `grant`, latches `uart_tx_byte` and `last_flag`, then moves to REQ.
- **REQ:** `uart_send_request`=1 for exactly this cycle. Clears the timeout counter and moves to WAIT_BUSY.
- **WAIT_BUSY:**
  - `uart_busy`=1 moves to WAIT_DONE.
  - Otherwise the counter increments. When it reaches `BUSY_TIMEOUT`, the block returns to REQ and retries the same byte.
- **WAIT_DONE:** waits for `uart_busy`=0.
  - If `uart_byte_available`=1 in that same cycle, the UART served an RX instead (collision). The block returns to REQ with the same byte, and `req_ready` stays low.
  - Otherwise `req_ready[g]`=1 this cycle.
  - If `last_flag` is set, `last_grant`<=g, `grant` clears, and the block returns to IDLE.
  - If `last_flag` is clear, the block moves to HOLD.
- **HOLD:**
  - Grant stays locked to g.
  - When `req_valid[g]`=1, the block latches the byte and `last_flag`, then moves to REQ.
  - Other requesters are ignored. HOLD has no timeout; a stalled owner locks the UART by design.
- **Byte stability:** `uart_tx_byte` is registered. It changes only on a latch (IDLE/HOLD exit) and is stable through the whole UART frame, because `uart` reads `tx_byte` live during TX.
- **Requester rules:**
  - Once `req_valid` is raised, it holds with stable `req_byte`/`req_last` until `req_ready`.
  - A requester must not drop `req_valid` mid-packet.
- **Reset:**
  - State → IDLE; `grant`=0; `req_ready`=0; `uart_send_request`=0; `uart_tx_byte`=0x00.
  - `last_grant`=NUM_REQ-1, so requester 0 wins first.
- **Reset mid-operation:** `uart` has no reset and may still be framing. The arbiter leaves IDLE only with `uart_busy`=0, so no request overlaps a frame in progress.

## Timing
- **First byte:**
  - Cycle 0 (IDLE, valid seen): grant registered.
  - Cycle 1: REQ, request pulse.
  - Cycle 2: WAIT_BUSY sees `uart_busy`=1.
  - Cycle 3: WAIT_DONE.
- **Per byte:** `req_ready` asserts in the first WAIT_DONE cycle with `uart_busy`=0, which is about 11 bit-times after REQ at the `uart` baud.
- **Gaps between bytes:**
  - HOLD→REQ adds one cycle between bytes of a packet.
  - End of packet→next grant costs one IDLE cycle.
- **Simultaneous events:**
  - `uart_busy` rising in IDLE (RX start) blocks granting.
  - RX and the request on the same edge are caught by the `byte_available` check and retried.
- **Round-robin:** with all requesters valid and single-byte packets, grant order is 0,1,2,3,0,… and the pointer wraps modulo NUM_REQ.

## Structure
- **`uart_pkg`:** arbiter state encoding, `CLK_HZ`=12000000, `BAUD`=115200, `CLKS_IN_BAUD`.
- **`rr_arbiter`:** the one sub-module. A combinational round-robin picker taking the request vector and `last_grant`, producing a one-hot winner plus a valid flag. It is reusable elsewhere.

## Test plan
- **Single byte:** reset; requester 2 valid, byte 0xA5, last=1 → `grant`=0100 in cycle 0; `uart_send_request` pulses one cycle; tx line carries start, 0xA5 LSB-first, stop; `req_ready[2]` pulses once; `grant`=0 afterwards.
- **Fairness:** all four requesters valid with single-byte packets 0x10/0x11/0x12/0x13 → bytes appear on tx in order 10,11,12,13,10; no requester is granted twice before the others.
- **Packet lock:**
  - Requester 1 sends 3 bytes (last on the 3rd) while requester 0 is valid.
  - Required: all 3 bytes of requester 1 go out contiguously before requester 0 is granted.
  - `uart_tx_byte` stays constant during each frame.
- **RX collision:** drive `rx` low in the same cycle as REQ → `uart_byte_available` pulses; `req_ready` stays low; the same byte is re-requested and sent; `req_ready` then pulses exactly once.
- **Reset mid-frame:**
  - Assert `rst` for 1 cycle during WAIT_DONE.
  - Required: all outputs return to reset values; no new request until `uart_busy` falls.
  - Requester 0 is served first afterwards.
- **Timeout:** hold `uart_busy` low (UART model stalled) → `uart_send_request` re-pulses every `BUSY_TIMEOUT`+1 cycles with an unchanged `uart_tx_byte`.
